// File: rtl/uart_tx_sched.sv
// Read-side scheduler for the UART TX FIFO: fetches one word at a time, screens parity errors,
// hands words to the serializer over valid/ready and spaces frames by a programmable gap.
module uart_tx_sched #(
  parameter int unsigned DW         = 8,
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          PERR_DROP  = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_enable,
  input  logic             i_flush,
  output logic             o_fifo_rd_req,
  input  logic [DW-1:0]    i_fifo_data,
  input  logic             i_fifo_valid,
  input  logic             i_fifo_empty,
  input  logic             i_fifo_perr,
  output logic [DW-1:0]    o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic             o_perr_pulse,
  output logic [CNT_W-1:0] o_perr_cnt
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GapLoad = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StPresent, StGap, StFlush} state_e;

  state_e           r_state, w_state_next;
  logic [DW-1:0]    r_data;
  logic             r_perr_pulse;
  logic [CNT_W-1:0] r_perr_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             w_hs;
  logic             w_perr_hit;

  assign w_hs       = (r_state == StPresent) && i_tx_ready;
  assign w_perr_hit = (r_state == StWait) && i_fifo_valid && i_fifo_perr;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_flush)                         w_state_next = StFlush;
        else if (i_enable && !i_fifo_empty)  w_state_next = StFetch;
      end
      StFetch: w_state_next = StWait;
      StWait: begin
        // Flush wins even over a good word: the captured data is simply never presented.
        if (i_flush)                         w_state_next = StFlush;
        else if (!i_fifo_valid)              w_state_next = StIdle;
        else if (i_fifo_perr && PERR_DROP)   w_state_next = StIdle;
        else                                 w_state_next = StPresent;
      end
      StPresent: begin
        if (i_tx_ready) w_state_next = (GAP_CYCLES > 0) ? StGap : StIdle;
      end
      StGap: begin
        if (i_flush)                w_state_next = StFlush;
        else if (r_gap_cnt == '0)   w_state_next = StIdle;
      end
      StFlush: begin
        if (i_fifo_empty && !i_flush) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_fifo_rd_req = (r_state == StFetch) || ((r_state == StFlush) && !i_fifo_empty);
    o_tx_valid    = (r_state == StPresent);
    o_busy        = (r_state != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_data       <= '0;
      r_perr_pulse <= 1'b0;
      r_perr_cnt   <= '0;
      r_gap_cnt    <= '0;
    end else begin
      if ((r_state == StWait) && i_fifo_valid) r_data <= i_fifo_data;
      r_perr_pulse <= w_perr_hit;
      if (w_perr_hit && (r_perr_cnt != '1)) r_perr_cnt <= r_perr_cnt + CNT_W'(1);
      if (w_hs)                                        r_gap_cnt <= GapLoad;
      else if ((r_state == StGap) && (r_gap_cnt != '0)) r_gap_cnt <= r_gap_cnt - GW'(1);
    end
  end

  assign o_tx_data    = r_data;
  assign o_perr_pulse = r_perr_pulse;
  assign o_perr_cnt   = r_perr_cnt;

endmodule
